// File: rtl/steer_en_ctrl.sv
// Rider-detect and steering-enable controller: qualifies load-cell weight and balance,
// then enables steering after the rider has stood still and balanced for a full timer period.
module steer_en_ctrl #(
    parameter int              LD_W         = 32'd12,
    parameter logic [LD_W-1:0] MIN_RIDER_WT = 12'h200,
    parameter logic [7:0]      WT_HYST      = 8'h40,
    parameter int              EN_SHIFT     = 32'd2,
    parameter int              DIS_SHIFT    = 32'd4,
    parameter int              TMR_W        = 32'd26,
    parameter int unsigned     TMR_FULL     = 32'd67000000,
    parameter bit              FAST_SIM     = 1'b1,
    parameter int              FAST_BITS    = 32'd15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [LD_W-1:0] lft_ld,
    input  logic [LD_W-1:0] rght_ld,
    input  logic            ld_vld,
    output logic            en_steer,
    output logic            rider_off,
    output logic [1:0]      state
);

    localparam int SW = LD_W + 32'd1;
    localparam logic [LD_W:0] MIN_X  = {1'b0, MIN_RIDER_WT};
    localparam logic [LD_W:0] HYST_X = SW'(WT_HYST);
    localparam logic [LD_W:0] LO_TH  = MIN_X - HYST_X;
    localparam logic [LD_W:0] HI_TH  = MIN_X + HYST_X;

    if ((MIN_RIDER_WT <= LD_W'(WT_HYST)) || (DIS_SHIFT <= EN_SHIFT) || (EN_SHIFT < 32'd1) ||
        (FAST_BITS > TMR_W) || (64'(TMR_FULL) > (64'd1 << TMR_W))) begin : g_param_err
        $error("steer_en_ctrl: illegal parameter set");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_STEER = 2'd2,
        ST_BAD   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              en_steer_q, rider_off_q;
    logic [TMR_W-1:0]  tmr_q;
    logic              sum_lt_q, sum_gt_q, d_en_q, d_dis_q;
    logic              clr_s, full_s;
    logic [LD_W:0]     sum_s, diff_s, en_th_s, dis_th_s;
    logic signed [LD_W+1:0] sdiff_s;

    // Weight sum, absolute left/right imbalance and the imbalance thresholds
    always_comb begin
        sum_s    = {1'b0, lft_ld} + {1'b0, rght_ld};
        sdiff_s  = $signed({2'b00, rght_ld}) - $signed({2'b00, lft_ld});
        if (sdiff_s[LD_W+1]) begin
            diff_s = SW'(-sdiff_s);
        end else begin
            diff_s = SW'(sdiff_s);
        end
        en_th_s  = sum_s >> EN_SHIFT;
        dis_th_s = sum_s - (sum_s >> DIS_SHIFT);
    end

    // Comparison flags captured only on valid samples so the FSM sees stable data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_lt_q <= 1'b0;
            sum_gt_q <= 1'b0;
            d_en_q   <= 1'b0;
            d_dis_q  <= 1'b0;
        end else if (ld_vld) begin
            sum_lt_q <= (sum_s < LO_TH);
            sum_gt_q <= (sum_s > HI_TH);
            d_en_q   <= (diff_s > en_th_s);
            d_dis_q  <= (diff_s > dis_th_s);
        end else begin
            sum_lt_q <= sum_lt_q;
            sum_gt_q <= sum_gt_q;
            d_en_q   <= d_en_q;
            d_dis_q  <= d_dis_q;
        end
    end

    if (FAST_SIM) begin : g_fast_full
        assign full_s = &tmr_q[FAST_BITS-1:0];
    end else begin : g_real_full
        assign full_s = (tmr_q == TMR_W'(TMR_FULL - 32'd1));
    end

    // Qualification timer: free-running, cleared by the FSM, saturating at full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr_q <= '0;
        end else if (clr_s) begin
            tmr_q <= '0;
        end else if (!full_s) begin
            tmr_q <= tmr_q + TMR_W'(1);
        end else begin
            tmr_q <= tmr_q;
        end
    end

    // Next-state and timer-clear decode; sum_lt outranks imbalance, imbalance outranks full
    always_comb begin
        state_d = state_q;
        clr_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sum_gt_q) begin
                    state_d = ST_WAIT;
                    clr_s   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (sum_lt_q) begin
                    state_d = ST_IDLE;
                end else if (d_en_q) begin
                    state_d = ST_WAIT;
                    clr_s   = 1'b1;
                end else if (full_s) begin
                    state_d = ST_STEER;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_STEER: begin
                if (sum_lt_q) begin
                    state_d = ST_IDLE;
                end else if (d_dis_q) begin
                    state_d = ST_WAIT;
                    clr_s   = 1'b1;
                end else begin
                    state_d = ST_STEER;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with outputs registered from the next state so they track state_q exactly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            en_steer_q  <= 1'b0;
            rider_off_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            en_steer_q  <= (state_d == ST_STEER);
            rider_off_q <= (state_d == ST_IDLE);
        end
    end

    assign en_steer  = en_steer_q;
    assign rider_off = rider_off_q;
    assign state     = state_q;

endmodule
